// File: rtl/lut_ctrl_pkg.sv
// Shared types and constants for the LUT arbiter/sweep controller.
// The seven codes below are the only inputs for which lut_1557 returns 0.
package lut_ctrl_pkg;

  localparam int NUM_CODES = 16;
  localparam int CODE_W    = 4;
  localparam int ONES_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CODE_W-1:0] A_ONE = 4'h1;
  localparam logic [CODE_W-1:0] B_ONE = 4'h2;
  localparam logic [CODE_W-1:0] C_ONE = 4'h4;
  localparam logic [CODE_W-1:0] D_ONE = 4'h7;
  localparam logic [CODE_W-1:0] E_ONE = 4'h8;
  localparam logic [CODE_W-1:0] F_ONE = 4'hB;
  localparam logic [CODE_W-1:0] G_ONE = 4'hD;

  // Saturation-free increment of the ones tally by a single LUT bit.
  function automatic logic [ONES_W-1:0] add_bit(input logic [ONES_W-1:0] acc, input logic b);
    add_bit = acc + {{(ONES_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/lut_1557.sv
// Fixed 4-input lookup: output is 1 except at the seven A_ONE..G_ONE codes.
import lut_ctrl_pkg::*;

module lut_1557 (
  input  logic [CODE_W-1:0] code,
  output logic              s
);

  // Table decode of the seven zero codes.
  always_comb begin
    s = 1'b1;
    case (code)
      A_ONE, B_ONE, C_ONE, D_ONE, E_ONE, F_ONE, G_ONE: s = 1'b0;
      default:                                         s = 1'b1;
    endcase
  end

endmodule

// File: rtl/lut_arb_ctrl.sv
// Two-requester round-robin front end to a shared LUT, with a full-table
// sweep mode that captures every LUT output and the count of ones.
import lut_ctrl_pkg::*;

module lut_arb_ctrl (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [CODE_W-1:0]    req0_code,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [CODE_W-1:0]    req1_code,
  output logic                 req1_ready,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic                 rsp_s,
  input  logic                 scan_start,
  output logic                 scan_busy,
  output logic                 scan_done,
  output logic [NUM_CODES-1:0] scan_map,
  output logic [ONES_W-1:0]    scan_ones
);

  state_e               state_r;
  state_e               state_nxt_s;
  logic [CODE_W-1:0]    cnt_r;
  logic                 prio_r;
  logic                 grant_s;
  logic                 ready0_s;
  logic                 ready1_s;
  logic                 xfer_s;
  logic [CODE_W-1:0]    lut_code_s;
  logic                 lut_s;
  logic                 rsp_valid_r;
  logic                 rsp_id_r;
  logic                 rsp_s_r;
  logic                 scan_busy_r;
  logic                 scan_done_r;
  logic [NUM_CODES-1:0] scan_map_r;
  logic [ONES_W-1:0]    scan_ones_r;

  lut_1557 u_lut (
    .code (lut_code_s),
    .s    (lut_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (scan_start) state_nxt_s = SCAN;
        else            state_nxt_s = IDLE;
      end
      SCAN: begin
        if (cnt_r == 4'hF) state_nxt_s = DONE;
        else               state_nxt_s = SCAN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: grant selection, handshakes and LUT input mux.
  always_comb begin
    grant_s    = 1'b0;
    ready0_s   = 1'b0;
    ready1_s   = 1'b0;
    lut_code_s = req0_code;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) grant_s = prio_r;
      else if (req1_valid)          grant_s = 1'b1;
      else                          grant_s = 1'b0;
      ready0_s = req0_valid && !grant_s;
      ready1_s = req1_valid && grant_s;
    end else begin
      grant_s  = 1'b0;
      ready0_s = 1'b0;
      ready1_s = 1'b0;
    end
    if (state_r == SCAN) lut_code_s = cnt_r;
    else if (grant_s)    lut_code_s = req1_code;
    else                 lut_code_s = req0_code;
  end

  assign xfer_s     = ready0_s || ready1_s;
  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;

  // Response pipeline and round-robin pointer (prio_r=1 favours requester 1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_s_r     <= 1'b0;
      prio_r      <= 1'b0;
    end else begin
      rsp_valid_r <= xfer_s;
      if (xfer_s) begin
        rsp_id_r <= grant_s;
        rsp_s_r  <= lut_s;
        prio_r   <= ~grant_s;
      end else begin
        rsp_id_r <= 1'b0;
        rsp_s_r  <= 1'b0;
        prio_r   <= prio_r;
      end
    end
  end

  // Sweep counter and result capture; results persist until the next sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= 4'h0;
      scan_map_r  <= 16'h0000;
      scan_ones_r <= 5'd0;
    end else if ((state_r == IDLE) && scan_start) begin
      cnt_r       <= 4'h0;
      scan_map_r  <= 16'h0000;
      scan_ones_r <= 5'd0;
    end else if (state_r == SCAN) begin
      scan_map_r[cnt_r] <= lut_s;
      scan_ones_r       <= add_bit(scan_ones_r, lut_s);
      if (cnt_r != 4'hF) cnt_r <= cnt_r + 4'h1;
      else               cnt_r <= cnt_r;
    end else begin
      cnt_r       <= cnt_r;
      scan_map_r  <= scan_map_r;
      scan_ones_r <= scan_ones_r;
    end
  end

  // Registered status flags, aligned with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_busy_r <= 1'b0;
      scan_done_r <= 1'b0;
    end else begin
      scan_busy_r <= (state_nxt_s == SCAN);
      scan_done_r <= (state_nxt_s == DONE);
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_s     = rsp_s_r;
  assign scan_busy = scan_busy_r;
  assign scan_done = scan_done_r;
  assign scan_map  = scan_map_r;
  assign scan_ones = scan_ones_r;

endmodule

// File: tb/tb_lut_arb_ctrl.sv
// Self-checking bench for lut_arb_ctrl: randomized requests against a
// behavioural arbiter/LUT model, plus directed sweep and reset scenarios.
module tb_lut_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_code, req1_code;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_s;
  logic        scan_start, scan_busy, scan_done;
  logic [15:0] scan_map;
  logic [4:0]  scan_ones;

  int   checks = 0;
  int   failures = 0;
  logic favour1;
  int   zero_codes [7] = '{1, 2, 4, 7, 8, 11, 13};

  always #5 clk = ~clk;

  lut_arb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_code(req0_code), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_code(req1_code), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_s(rsp_s),
    .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
    .scan_map(scan_map), .scan_ones(scan_ones)
  );

  function automatic logic ref_lut(input logic [3:0] c);
    for (int i = 0; i < 7; i++) if (int'(c) == zero_codes[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] ref_map();
    logic [15:0] m;
    m = 16'h0000;
    for (int k = 0; k < 16; k++) m[k] = ref_lut(k[3:0]);
    return m;
  endfunction

  function automatic int ref_ones();
    int n;
    n = 0;
    for (int k = 0; k < 16; k++) n += int'(ref_lut(k[3:0]));
    return n;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; req0_code = 4'h0; req1_code = 4'h0;
    scan_start = 1'b0; rst_n = 1'b0;
    #3;
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0 || rsp_s !== 1'b0) begin failures++; $display("FAIL reset_rsp_data got=%b%b exp=00", rsp_id, rsp_s); end
    checks++; if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin failures++; $display("FAIL reset_scan_flags got=%b%b exp=00", scan_busy, scan_done); end
    checks++; if (scan_map !== 16'h0000 || scan_ones !== 5'd0) begin failures++; $display("FAIL reset_scan_res got=%h/%0d exp=0000/0", scan_map, scan_ones); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    favour1 = 1'b0;
    tick();
  endtask

  // Both requesters valid every cycle: grants alternate starting with 0.
  task automatic test_alternate();
    logic [3:0] c0, c1;
    logic       eid;
    for (int i = 0; i < 6; i++) begin
      c0 = 4'($urandom); c1 = 4'($urandom);
      req0_valid = 1'b1; req1_valid = 1'b1; req0_code = c0; req1_code = c1;
      #1;
      eid = (i % 2 == 1);
      checks++; if (req0_ready !== !eid || req1_ready !== eid) begin failures++; $display("FAIL alt_ready i=%0d got=%b%b exp=%b%b", i, req1_ready, req0_ready, eid, !eid); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== eid || rsp_s !== ref_lut(eid ? c1 : c0)) begin
        failures++; $display("FAIL alt_rsp i=%0d got=v%b id%b s%b exp=v1 id%b s%b", i, rsp_valid, rsp_id, rsp_s, eid, ref_lut(eid ? c1 : c0));
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    favour1 = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL alt_idle_rsp got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_single_req1();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_code = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin failures++; $display("FAIL req1_ready i=%0d got=%b%b exp=10", i, req1_ready, req0_ready); end
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_s !== ref_lut(4'hF)) begin
        failures++; $display("FAIL req1_rsp i=%0d got=v%b id%b s%b exp=v1 id1 s%b", i, rsp_valid, rsp_id, rsp_s, ref_lut(4'hF));
      end
    end
    req1_valid = 1'b0;
    favour1 = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL req1_tail got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_random();
    logic v0, v1;
    logic [3:0] c0, c1;
    int winner;
    for (int n = 0; n < 300; n++) begin
      v0 = 1'($urandom); v1 = 1'($urandom); c0 = 4'($urandom); c1 = 4'($urandom);
      req0_valid = v0; req1_valid = v1; req0_code = c0; req1_code = c1;
      #1;
      if (v0 && v1) winner = favour1 ? 1 : 0;
      else if (v1)  winner = 1;
      else if (v0)  winner = 0;
      else          winner = -1;
      checks++; if (req0_ready !== (winner == 0) || req1_ready !== (winner == 1)) begin
        failures++; $display("FAIL rand_ready n=%0d got=%b%b exp_winner=%0d", n, req1_ready, req0_ready, winner);
      end
      tick();
      checks++; if (rsp_valid !== (winner >= 0)) begin failures++; $display("FAIL rand_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid, winner >= 0); end
      if (winner >= 0) begin
        checks++; if (rsp_id !== (winner == 1) || rsp_s !== ref_lut(winner == 1 ? c1 : c0)) begin
          failures++; $display("FAIL rand_rsp_data n=%0d got=id%b s%b exp=id%0d s%b", n, rsp_id, rsp_s, winner, ref_lut(winner == 1 ? c1 : c0));
        end
        favour1 = (winner == 0);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  // Full sweep; optionally hold scan_start high and/or keep req0 waiting.
  task automatic test_sweep(input bit hold_start, input bit req0_during);
    logic [3:0] c0;
    c0 = 4'($urandom);
    req0_valid = 1'b0; req1_valid = 1'b0; scan_start = 1'b1;
    tick();
    if (!hold_start) scan_start = 1'b0;
    req0_valid = req0_during; req0_code = c0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      checks++; if (scan_busy !== 1'b1 || scan_done !== 1'b0 || req0_ready !== 1'b0) begin
        failures++; $display("FAIL sweep_busy k=%0d got=b%b d%b r%b exp=b1 d0 r0", k, scan_busy, scan_done, req0_ready);
      end
      tick();
    end
    #1;
    checks++; if (scan_done !== 1'b1 || scan_busy !== 1'b0 || req0_ready !== 1'b0) begin
      failures++; $display("FAIL sweep_done got=d%b b%b r%b exp=d1 b0 r0", scan_done, scan_busy, req0_ready);
    end
    checks++; if (scan_map !== ref_map() || int'(scan_ones) != ref_ones()) begin
      failures++; $display("FAIL sweep_result got=%h/%0d exp=%h/%0d", scan_map, scan_ones, ref_map(), ref_ones());
    end
    scan_start = 1'b0;
    tick();
    #1;
    checks++; if (scan_done !== 1'b0 || scan_busy !== 1'b0 || scan_map !== ref_map()) begin
      failures++; $display("FAIL sweep_idle got=d%b b%b map=%h exp=d0 b0 map=%h", scan_done, scan_busy, scan_map, ref_map());
    end
    if (req0_during) begin
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL sweep_req0_ready got=%b exp=1", req0_ready); end
      tick();
      req0_valid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_s !== ref_lut(c0)) begin
        failures++; $display("FAIL sweep_req0_rsp got=v%b id%b s%b exp=v1 id0 s%b", rsp_valid, rsp_id, rsp_s, ref_lut(c0));
      end
      favour1 = 1'b1;
    end
    tick();
  endtask

  task automatic test_start_with_req();
    logic [3:0] c0;
    c0 = 4'($urandom);
    scan_start = 1'b1; req0_valid = 1'b1; req0_code = c0; req1_valid = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL start_req_ready got=%b exp=1", req0_ready); end
    tick();
    scan_start = 1'b0; req0_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_s !== ref_lut(c0) || scan_busy !== 1'b1) begin
      failures++; $display("FAIL start_req_rsp got=v%b id%b s%b b%b exp=v1 id0 s%b b1", rsp_valid, rsp_id, rsp_s, scan_busy, ref_lut(c0));
    end
    favour1 = 1'b1;
    repeat (16) tick();
    checks++; if (scan_done !== 1'b1 || int'(scan_ones) != ref_ones()) begin
      failures++; $display("FAIL start_req_done got=d%b ones=%0d exp=d1 ones=%0d", scan_done, scan_ones, ref_ones());
    end
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    scan_start = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    scan_start = 1'b0;
    repeat (7) tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (scan_busy !== 1'b0 || scan_done !== 1'b0 || scan_map !== 16'h0000 || scan_ones !== 5'd0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL midreset got=b%b d%b map=%h ones=%0d v%b exp=all zero", scan_busy, scan_done, scan_map, scan_ones, rsp_valid);
    end
    #3 rst_n = 1'b1;
    favour1 = 1'b0;
    tick();
    test_alternate();
    test_sweep(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alternate();
    test_single_req1();
    test_random();
    test_sweep(1'b0, 1'b0);
    test_sweep(1'b0, 1'b1);
    test_sweep(1'b1, 1'b0);
    test_start_with_req();
    test_random();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_arb_ctrl.md
LUT_ARB_CTRL -- requirements
Module: lut_arb_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req0_valid, input, 1, requester 0 has a code to evaluate.
REQ-004 SHALL have port req0_code, input, 4, requester 0 code.
REQ-005 SHALL have port req0_ready, output, 1, requester 0 code accepted this cycle.
REQ-006 SHALL have ports req1_valid, input, 1; req1_code, input, 4; req1_ready, output, 1; same meanings for requester 1.
REQ-007 SHALL have port rsp_valid, output, 1, response strobe.
REQ-008 SHALL have port rsp_id, output, 1, requester the response belongs to.
REQ-009 SHALL have port rsp_s, output, 1, LUT result for the accepted code.
REQ-010 SHALL have port scan_start, input, 1, request a full 16-code table sweep.
REQ-011 SHALL have port scan_busy, output, 1, sweep in progress.
REQ-012 SHALL have port scan_done, output, 1, one-cycle sweep-complete pulse.
REQ-013 SHALL have port scan_map, output, 16, bit k = LUT output for code k.
REQ-014 SHALL have port scan_ones, output, 5, count of ones in scan_map (0..16).

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-016 In IDLE, SHALL grant at most one requester per cycle; readyN SHALL be combinational, high only for the granted requester and only when its valid is high.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted most recently; with one valid, grant it; pointer updates only on a transfer (valid && ready).
REQ-018 A transfer at edge t SHALL produce rsp_valid=1, rsp_id=granted index, rsp_s=LUT(code) in cycle t+1 (registered, one-cycle latency, one cycle wide); rsp_valid SHALL be 0 in all other cycles.
REQ-019 Back-to-back transfers SHALL be accepted every cycle (full throughput, no bubbles).
REQ-020 scan_start sampled high in IDLE SHALL move FSM to SCAN next cycle; a request transfer in that same cycle SHALL still complete normally.
REQ-021 In SCAN, both readyN SHALL be 0, scan_busy=1, and a 4-bit counter SHALL drive codes 0..15 into the LUT, one per cycle, writing scan_map[counter] and accumulating scan_ones.
REQ-022 scan_map and scan_ones SHALL be cleared on SCAN entry; counter 15 SHALL transition to DONE.
REQ-023 DONE SHALL last exactly one cycle with scan_done=1 and final scan_map/scan_ones valid, then return to IDLE; results SHALL hold until the next scan entry.
REQ-024 scan_start SHALL be ignored in SCAN and DONE; the counter SHALL not wrap beyond 15.
REQ-025 Sweep timing: scan_start sampled at edge t -> SCAN cycles t+1..t+16, scan_done in cycle t+17.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, counter 0, round-robin pointer favouring requester 0, and all outputs 0 (rsp_*, scan_busy, scan_done, scan_map, scan_ones), including mid-sweep.
REQ-027 After rst_n deasserts, the first grant with both valid SHALL go to requester 0.

Structure
REQ-028 Package lut_ctrl_pkg SHALL hold the state enum, NUM_CODES=16, and CODE_W=4.
REQ-029 SHALL instantiate exactly one lut_1557, fed by a mux selecting the scan counter in SCAN, otherwise the granted requester code.

Verification
REQ-030 Reset, then req0 and req1 valid every cycle -> ready alternates 0,1,0,1; rsp_id follows one cycle later.
REQ-031 Only req1 valid, code 4'hF for 3 cycles -> 3 transfers, rsp_valid high 3 consecutive cycles, rsp_id=1, rsp_s=LUT(4'hF).
REQ-032 scan_start pulse at cycle 10 -> scan_busy in cycles 11-26, scan_done in cycle 27, scan_ones=9, scan_map bits 0 exactly at the seven `Aone..`Gone codes.
REQ-033 req0 valid during a sweep -> req0_ready=0 throughout SCAN/DONE; transfer in the first IDLE cycle after.
REQ-034 rst_n low at sweep cycle 8 -> all outputs 0 asynchronously; a fresh sweep afterwards yields scan_ones=9.
REQ-035 scan_start and req0_valid in the same IDLE cycle -> req0 transfer completes (rsp next cycle), sweep starts next cycle.
